// File: rtl/mem_access_stage.sv
// MIPS MEM stage: branch resolution, data-memory access over a req/ack handshake,
// upstream stall while an access is in flight, and the MEM/WB pipeline register.
// Optional feature macro: MEM_TIMEOUT_EN (abort an access after TIMEOUT_CYCLES
// ACCESS cycles without ack and pulse bus_err).
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctl_in,
  input  logic [2:0]  m_ctl_in,
  input  logic [31:0] add_result,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2,
  input  logic [4:0]  wr_reg,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [1:0]  wb_ctl_out,
  output logic [31:0] read_data,
  output logic [31:0] alu_result_out,
  output logic [4:0]  wr_reg_out,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StAccess   = 2'b01,
    StComplete = 2'b10
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        w_stall;
  logic        w_memop;
  logic        w_is_store;
  logic        w_timeout;

  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [1:0]  r_wb_ctl_out;
  logic [31:0] r_read_data;
  logic [31:0] r_alu_result_out;
  logic [4:0]  r_wr_reg_out;

  // A zero timeout would abort every access before memory could answer.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // MemWrite wins when both MemRead and MemWrite are set.
  assign w_memop    = m_ctl_in[1] | m_ctl_in[0];
  assign w_is_store = m_ctl_in[0];

  // Branch resolution is independent of the access FSM.
  assign pcsrc         = m_ctl_in[2] & zero;
  assign branch_target = add_result;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] r_cnt;
  logic            r_bus_err;

  // ACCESS cycle counter; held at zero outside ACCESS so each access starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != StAccess) begin
      r_cnt <= '0;
    end else if (!w_timeout) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  // Timeout fires on the edge closing the last allowed ACCESS cycle; ack has priority.
  assign w_timeout = (r_state == StAccess) && !dmem_ack &&
                     (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  // One-cycle abort pulse, visible during the COMPLETE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
    end
  end

  assign bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and stall decode.
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_memop) begin
          w_stall      = 1'b1;
          w_state_next = StAccess;
        end
      end
      StAccess: begin
        w_stall = 1'b1;
        if (dmem_ack || w_timeout) begin
          w_state_next = StComplete;
        end
      end
      StComplete: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Reset forces stall low at once even if a memop is presented on the inputs.
  assign stall = w_stall & rst_n;

  // Memory request side: launch from IDLE, hold until ack or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else begin
      if (r_state == StIdle && w_memop) begin
        r_dmem_req   <= 1'b1;
        r_dmem_we    <= w_is_store;
        r_dmem_addr  <= alu_result;
        r_dmem_wdata <= rdata2;
      end else if (r_state == StAccess && (dmem_ack || w_timeout)) begin
        r_dmem_req <= 1'b0;
      end
    end
  end

  // Load data capture; stores and aborted accesses leave zero behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data <= '0;
    end else if (r_state == StAccess) begin
      if (dmem_ack) begin
        r_read_data <= r_dmem_we ? 32'h0 : dmem_rdata;
      end else if (w_timeout) begin
        r_read_data <= '0;
      end
    end
  end

  // MEM/WB register: bubble while stalled, otherwise capture the held EX/MEM fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_ctl_out     <= 2'b00;
      r_alu_result_out <= '0;
      r_wr_reg_out     <= '0;
    end else if (w_stall) begin
      r_wb_ctl_out <= 2'b00;
    end else begin
      r_wb_ctl_out     <= wb_ctl_in;
      r_alu_result_out <= alu_result;
      r_wr_reg_out     <= wr_reg;
    end
  end

  assign dmem_req       = r_dmem_req;
  assign dmem_we        = r_dmem_we;
  assign dmem_addr      = r_dmem_addr;
  assign dmem_wdata     = r_dmem_wdata;
  assign wb_ctl_out     = r_wb_ctl_out;
  assign read_data      = r_read_data;
  assign alu_result_out = r_alu_result_out;
  assign wr_reg_out     = r_wr_reg_out;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver pushes the expected MEM/WB
// contents of each instruction, a monitor pops and compares when it retires.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_ctl_in;
  logic [2:0]  m_ctl_in;
  logic [31:0] add_result;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2;
  logic [4:0]  wr_reg;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [1:0]  wb_ctl_out;
  logic [31:0] read_data;
  logic [31:0] alu_result_out;
  logic [4:0]  wr_reg_out;
  logic        bus_err;

  mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_ctl_in      (wb_ctl_in),
    .m_ctl_in       (m_ctl_in),
    .add_result     (add_result),
    .zero           (zero),
    .alu_result     (alu_result),
    .rdata2         (rdata2),
    .wr_reg         (wr_reg),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .pcsrc          (pcsrc),
    .branch_target  (branch_target),
    .stall          (stall),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .wb_ctl_out     (wb_ctl_out),
    .read_data      (read_data),
    .alu_result_out (alu_result_out),
    .wr_reg_out     (wr_reg_out),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [31:0] rd;
    bit          chk_rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   issue_active = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: an instruction retires on a posedge where it is presented and not stalled.
  initial begin
    forever begin
      bit   pend;
      exp_t e;
      @(negedge clk);
      #2;
      pend = issue_active && !stall && rst_n;
      @(posedge clk);
      #1;
      if (pend) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL retire: got retirement expected none queued");
        end else begin
          e = sb_q.pop_front();
          chk({e.name, " wb_ctl_out"}, 32'(wb_ctl_out), 32'(e.wb));
          chk({e.name, " alu_result_out"}, alu_result_out, e.alu);
          chk({e.name, " wr_reg_out"}, 32'(wr_reg_out), 32'(e.wr));
          if (e.chk_rd) chk({e.name, " read_data"}, read_data, e.rd);
        end
      end
    end
  end

  // Driver plus memory responder: ack arrives in ACCESS cycle ack_delay+1.
  task automatic issue(input string nm, input logic [1:0] wb, input logic [2:0] m,
                       input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wr,
                       input int ack_delay, input logic [31:0] rdata,
                       input logic [31:0] exp_rd, input bit chk_rd, input int exp_stall,
                       input bit noise_ack);
    exp_t e;
    int   sc;
    int   acc;
    bit   done;
    @(negedge clk);
    wb_ctl_in  = wb;
    m_ctl_in   = m;
    alu_result = alu;
    rdata2     = rd2;
    wr_reg     = wr;
    e.name = nm; e.wb = wb; e.alu = alu; e.wr = wr; e.rd = exp_rd; e.chk_rd = chk_rd;
    sb_q.push_back(e);
    issue_active = 1'b1;
    sc = 0; acc = 0; done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      if (stall) sc++;
      else done = 1'b1;
      if (dmem_req) begin
        if (acc == 0) begin
          chk({nm, " dmem_addr"}, dmem_addr, alu);
          chk({nm, " dmem_we"}, 32'(dmem_we), 32'(m[0]));
          if (m[0]) chk({nm, " dmem_wdata"}, dmem_wdata, rd2);
        end
        chk({nm, " bubble wb_ctl_out"}, 32'(wb_ctl_out), 32'd0);
        acc++;
        dmem_ack   = (acc > ack_delay);
        dmem_rdata = dmem_ack ? rdata : 32'hDEADBEEF;
      end else begin
        dmem_ack   = noise_ack;
        dmem_rdata = 32'hBAD0BAD0;
      end
      @(negedge clk);
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s retire bound: got stall still high expected release", nm);
    end
    chk({nm, " stall cycles"}, sc, exp_stall);
    issue_active = 1'b0;
    m_ctl_in     = 3'b000;
    wb_ctl_in    = 2'b00;
    dmem_ack     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wb_ctl_in = '0; m_ctl_in = '0; add_result = '0; zero = 1'b0;
    alu_result = '0; rdata2 = '0; wr_reg = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    #1;
    chk("reset dmem_req", 32'(dmem_req), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset wb_ctl_out", 32'(wb_ctl_out), 32'd0);
    chk("reset read_data", read_data, 32'd0);
    chk("reset alu_result_out", alu_result_out, 32'd0);
    chk("reset wr_reg_out", 32'(wr_reg_out), 32'd0);
    chk("reset dmem_addr", dmem_addr, 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //     name        wb     m       alu           rdata2        wr  dly rdata         exp_rd      chk stl noise
    issue("rtype",     2'b10, 3'b000, 32'h5,        32'h0,        8,  0, 32'h0,        32'h0,        0, 0, 0);
    issue("rtype_ack", 2'b10, 3'b000, 32'hA5A5,     32'h0,        31, 0, 32'h0,        32'h0,        0, 0, 1);
    chk("ack outside ACCESS dmem_req", 32'(dmem_req), 32'd0);
    issue("load",      2'b11, 3'b010, 32'h40,       32'h11111111, 9,  3, 32'h12345678, 32'h12345678, 1, 5, 0);
    issue("store",     2'b00, 3'b001, 32'h80,       32'hCAFEF00D, 3,  0, 32'h0,        32'h0,        1, 2, 0);
    issue("load_fast", 2'b11, 3'b010, 32'h44,       32'h0,        10, 0, 32'h0BADF00D, 32'h0BADF00D, 1, 2, 0);
    issue("rd_and_wr", 2'b10, 3'b011, 32'h90,       32'h55AA55AA, 11, 1, 32'hFFFFFFFF, 32'h0,        1, 3, 0);
    issue("load_wait", 2'b11, 3'b010, 32'h48,       32'h0,        12, 1, 32'h76543210, 32'h76543210, 1, 3, 0);

    // Branch resolution is combinational.
    @(negedge clk);
    m_ctl_in = 3'b100; zero = 1'b1; add_result = 32'h100;
    #1;
    chk("pcsrc taken", 32'(pcsrc), 32'd1);
    chk("branch_target", branch_target, 32'h100);
    chk("branch stall", 32'(stall), 32'd0);
    zero = 1'b0;
    #1;
    chk("pcsrc zero=0", 32'(pcsrc), 32'd0);
    m_ctl_in = 3'b000; zero = 1'b1;
    #1;
    chk("pcsrc branch=0", 32'(pcsrc), 32'd0);
    zero = 1'b0;

    // Access with no ack.
    @(negedge clk);
    wb_ctl_in = 2'b11; m_ctl_in = 3'b010; alu_result = 32'h200; wr_reg = 5'd4;
`ifdef MEM_TIMEOUT_EN
    begin
      int acc;
      acc = 0;
      @(negedge clk);
      for (int cyc = 0; cyc < 64; cyc++) begin
        #1;
        if (!dmem_req) break;
        acc++;
        @(negedge clk);
      end
      chk("timeout access cycles", acc, 16);
      chk("timeout bus_err", 32'(bus_err), 32'd1);
      chk("timeout read_data", read_data, 32'd0);
      chk("timeout dmem_req", 32'(dmem_req), 32'd0);
      chk("timeout stall", 32'(stall), 32'd0);
      @(negedge clk);
      #1;
      chk("timeout bus_err pulse", 32'(bus_err), 32'd0);
      @(negedge clk);
    end
`else
    for (int cyc = 0; cyc < 40; cyc++) @(negedge clk);
    #1;
    chk("no ack stall held", 32'(stall), 32'd1);
    chk("no ack dmem_req held", 32'(dmem_req), 32'd1);
    chk("no ack bus_err", 32'(bus_err), 32'd0);
`endif

    // Reset mid-ACCESS.
    @(negedge clk);
    #1;
    chk("pre-reset dmem_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid reset dmem_req", 32'(dmem_req), 32'd0);
    chk("mid reset stall", 32'(stall), 32'd0);
    chk("mid reset wb_ctl_out", 32'(wb_ctl_out), 32'd0);
    chk("mid reset read_data", read_data, 32'd0);
    @(negedge clk);
    m_ctl_in = 3'b000; wb_ctl_in = 2'b00;
    rst_n = 1'b1;
    #1;
    chk("post reset stall", 32'(stall), 32'd0);
    issue("rtype_post", 2'b01, 3'b000, 32'h33,  32'h0, 1, 0, 32'h0,        32'h0,        0, 0, 0);
    issue("load_post",  2'b11, 3'b010, 32'h4C,  32'h0, 2, 0, 32'h01020304, 32'h01020304, 1, 2, 0);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
